// File: rtl/imm_extend_pipe.sv
// Immediate extractor/extender for D, CB, B, I and IW formats, with a registered output stage and a one-entry skid buffer.
// Define IMMX_BRANCH_SHL2_EN to turn CB/B word offsets into byte offsets (left shift by 2).
module imm_extend_pipe #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [2:0]         in_fmt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_imm,
    output logic               out_err
);

`ifdef IMMX_BRANCH_SHL2_EN
    localparam int unsigned BR_SHL = 2;
`else
    localparam int unsigned BR_SHL = 0;
`endif

    typedef struct packed {
        logic        err;
        logic [63:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [25:0] ins, input logic [2:0] fmt);
        dec_t               r;
        logic signed [63:0] s;
        r = '0;
        s = '0;
        case (fmt)
            3'd0: begin
                s     = {{55{ins[20]}}, ins[20:12]};
                r.imm = s;
            end
            3'd1: begin
                s     = {{45{ins[23]}}, ins[23:5]};
                r.imm = s <<< BR_SHL;
            end
            3'd2: begin
                s     = {{38{ins[25]}}, ins[25:0]};
                r.imm = s <<< BR_SHL;
            end
            3'd3: r.imm = {52'd0, ins[21:10]};
            3'd4: begin
                // A 32-bit result cannot hold a 16-bit chunk placed at bit 32 or 48.
                if (DATA_W == 32 && ins[22]) r.err = 1'b1;
                else r.imm = {48'd0, ins[20:5]} << {ins[22:21], 4'd0};
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    dec_t dec;
    logic unused_bits;

    assign dec         = decode(in_instr[25:0], in_fmt);
    assign unused_bits = ^{in_instr[INSTR_W-1:26], dec};

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q, out_imm_d;
    logic              out_err_q, out_err_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
    logic              skid_err_q, skid_err_d;
    logic              accept, drain;

    assign in_ready  = !skid_valid_q;
    assign accept    = in_valid && !skid_valid_q;
    assign drain     = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_err   = out_err_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_err_d    = out_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_err_d   = skid_err_q;
        if (drain && skid_valid_q) begin
            out_imm_d    = skid_imm_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
        end else if (accept) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec.imm[DATA_W-1:0];
                out_err_d   = dec.err;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec.imm[DATA_W-1:0];
                skid_err_d   = dec.err;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_err_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_err_q    <= out_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_err_q   <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 64-bit and 32-bit instances driven from the same inputs.
module tb_imm_extend_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_fmt;
    logic        out_ready;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;

    int total = 0;
    int bad   = 0;

`ifdef IMMX_BRANCH_SHL2_EN
    localparam longint BRMUL = 4;
`else
    localparam longint BRMUL = 1;
`endif

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_W(64), .INSTR_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_err(out_err64));

    imm_extend_pipe #(.DATA_W(32), .INSTR_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_err(out_err32));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sign extension via arithmetic right shift, branch scaling and IW placement via multiplication.
    function automatic logic [64:0] model64(input logic [31:0] ins, input logic [2:0] f);
        longint     v;
        logic [63:0] r;
        logic        e;
        r = 64'd0;
        e = 1'b0;
        case (f)
            3'd0: begin v = $signed({ins[20:12], 55'd0}) >>> 55; r = v; end
            3'd1: begin v = $signed({ins[23:5], 45'd0}) >>> 45; r = v * BRMUL; end
            3'd2: begin v = $signed({ins[25:0], 38'd0}) >>> 38; r = v * BRMUL; end
            3'd3: r = 64'(ins[21:10]);
            3'd4: r = 64'(ins[20:5]) * (64'd1 << (16 * ins[22:21]));
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    function automatic logic [64:0] model32(input logic [31:0] ins, input logic [2:0] f);
        logic [64:0] m;
        m = model64(ins, f);
        if (m[64] || (f == 3'd4 && ins[22])) return {1'b1, 64'd0};
        return {1'b0, 32'd0, m[31:0]};
    endfunction

    initial begin
        logic [64:0] e64, e32;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_fmt    = 3'd0;
        out_ready = 1'b1;
        #1;
        check("rst_out_valid", {63'd0, out_valid64}, 64'd0);
        check("rst_out_imm", out_imm64, 64'd0);
        check("rst_out_err", {63'd0, out_err64}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        check("rst_in_ready", {63'd0, in_ready64}, 64'd1);

        // D format, all-ones field
        tick();
        in_valid = 1'b1; in_fmt = 3'd0; in_instr = 32'h001F_F000;
        tick();
        in_valid = 1'b0;
        check("d_valid", {63'd0, out_valid64}, 64'd1);
        check("d_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("d_err64", {63'd0, out_err64}, 64'd0);
        check("d_imm32", {32'd0, out_imm32}, 64'h0000_0000_FFFF_FFFF);

        // CB format, only field MSB set
        in_valid = 1'b1; in_fmt = 3'd1; in_instr = 32'h0080_0000;
        tick();
        in_valid = 1'b0;
`ifdef IMMX_BRANCH_SHL2_EN
        check("cb_imm64", out_imm64, 64'hFFFF_FFFF_FFF0_0000);
`else
        check("cb_imm64", out_imm64, 64'hFFFF_FFFF_FFFC_0000);
`endif

        // I format zero-extends even with high instruction bits set
        in_valid = 1'b1; in_fmt = 3'd3; in_instr = 32'h802A_F000;
        tick();
        in_valid = 1'b0;
        check("i_imm64", out_imm64, 64'h0000_0000_0000_0ABC);

        // IW with shift 3: legal for 64, error for 32
        in_valid = 1'b1; in_fmt = 3'd4; in_instr = 32'h0062_4680;
        tick();
        in_valid = 1'b0;
        check("iw_imm64", out_imm64, 64'h1234_0000_0000_0000);
        check("iw_err64", {63'd0, out_err64}, 64'd0);
        check("iw_imm32", {32'd0, out_imm32}, 64'd0);
        check("iw_err32", {63'd0, out_err32}, 64'd1);

        // Illegal format
        in_valid = 1'b1; in_fmt = 3'd6; in_instr = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        check("ill_imm64", out_imm64, 64'd0);
        check("ill_err64", {63'd0, out_err64}, 64'd1);
        check("ill_err32", {63'd0, out_err32}, 64'd1);
        tick();
        check("idle_valid", {63'd0, out_valid64}, 64'd0);

        // Backpressure: three I-type immediates 1, 2, 3 with consumer stalled
        out_ready = 1'b0;
        in_valid = 1'b1; in_fmt = 3'd3; in_instr = 32'd1 << 10;
        tick();
        check("bp_first_imm", out_imm64, 64'd1);
        check("bp_ready_after1", {63'd0, in_ready64}, 64'd1);
        in_instr = 32'd2 << 10;
        tick();
        check("bp_ready_after2", {63'd0, in_ready64}, 64'd0);
        in_instr = 32'd3 << 10;
        tick();
        check("bp_hold_imm", out_imm64, 64'd1);
        check("bp_hold_ready", {63'd0, in_ready64}, 64'd0);
        tick();
        check("bp_hold_imm2", out_imm64, 64'd1);
        out_ready = 1'b1;
        check("bp_drain1", out_imm64, 64'd1);
        tick();
        check("bp_drain2", out_imm64, 64'd2);
        check("bp_ready_again", {63'd0, in_ready64}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_drain3", out_imm64, 64'd3);
        check("bp_valid3", {63'd0, out_valid64}, 64'd1);
        tick();
        check("bp_empty", {63'd0, out_valid64}, 64'd0);

        // Streaming against the reference model
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_instr = $urandom;
            in_fmt   = 3'($urandom_range(0, 7));
            e64 = model64(in_instr, in_fmt);
            e32 = model32(in_instr, in_fmt);
            tick();
            check("st_valid", {62'd0, out_valid64, in_ready64}, 64'd3);
            check("st_imm64", out_imm64, e64[63:0]);
            check("st_err64", {63'd0, out_err64}, {63'd0, e64[64]});
            check("st_res32", {31'd0, out_err32, out_imm32}, {31'd0, e32[64], e32[31:0]});
        end
        in_valid = 1'b0;
        tick();

        // Async reset with main and skid full
        out_ready = 1'b0;
        in_valid = 1'b1; in_fmt = 3'd3; in_instr = 32'd5 << 10;
        tick();
        in_instr = 32'd6 << 10;
        tick();
        in_valid = 1'b0;
        check("ar_full", {62'd0, out_valid64, in_ready64}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {63'd0, out_valid64}, 64'd0);
        check("ar_imm", out_imm64, 64'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("ar_in_ready", {63'd0, in_ready64}, 64'd1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'd7 << 10;
        tick();
        in_valid = 1'b0;
        check("ar_next", {out_valid64, out_imm64[62:0]}, {1'b1, 63'd7});
        tick();
        check("ar_gone", {63'd0, out_valid64}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
